serv_bufreg_wide: RTL and testbench
===================================

// Module: serv_bufreg_wide
// PURPOSE
//  Digit-serial buffer register for the SERV datapath.
//  - Adds rs1 and the immediate W bits per cycle and shifts the result into a 32-bit register.
//    The register supplies the data-bus address, the low address bits (o_lsb) and the shift operand.
//  - Works at any supported datapath width W, counts its own digits and signals the last one.
//  - Keeps the carry across stalls and clears it at the end of each pass.
// PARAMETERS
//  W    4  datapath digit width; legal values 1,2,4,8; any other value is an elaboration error
//  MDU  0  1 = multiply/divide extension is present (gates o_q and o_lsb during MDU ops)
//  B    W-1  derived; do not override
// PORTS
//  i_clk        in   1   clock, rising edge
//  i_rst_n      in   1   asynchronous active-low reset
//  i_en         in   1   digit strobe; the state advances only when i_en is high
//  i_init       in   1   1 = load the sum of rs1 and imm; 0 = shift the register right
//  i_mdu_op     in   1   current instruction is an MDU operation
//  i_rs1_en     in   1   include i_rs1 in the sum
//  i_imm_en     in   1   include i_imm in the sum
//  i_clr_lsb    in   1   force imm bit 0 to zero on digit 0 (used by JALR)
//  i_sh_signed  in   1   arithmetic right shift: fill with data[31]
//  i_rs1        in   W   rs1 digit, least significant digit first
//  i_imm        in   W   immediate digit, least significant digit first
//  o_q          out  W   data[B:0]
//  o_lsb        out  2   bits [1:0] of the last loaded sum
//  o_cnt        out  log2(32/W) (1 bit min)  current digit index
//  o_last       out  1   o_cnt == 32/W-1
//  o_dbus_adr   out  32  {data[31:2],2'b00}
//  o_ext_rs1    out  32  data
// BEHAVIOUR
//  Reset (async, i_rst_n=0): data, carry, cnt and lsb all go to 0.
//    As a result o_q=0, o_lsb=0, o_cnt=0, o_last=0 and o_dbus_adr=0 immediately.
//    A reset during a pass aborts it; the next pass starts at digit 0.
//  Digit counter:
//    - cnt increments when i_en=1 and wraps from 32/W-1 to 0.
//    - When i_en=0, cnt holds.
//    - A pass is 32/W enabled cycles.
//  Adder: {c,q} = (i_rs1&{W{i_rs1_en}}) + (i_imm&{W{i_imm_en}}&~m) + cr.
//    - m is a W-bit mask. Its bit 0 is (cnt==0 & i_clr_lsb); every other bit is 0.
//    - cr is a 1-bit carry register.
//  Carry:
//    - When i_en=1 and o_last=0: cr <= c.
//    - When i_en=1 and o_last=1: cr <= 0, so no carry leaks into the next pass.
//    - When i_en=0: cr holds, so a stall in the middle of a pass does not change the result.
//  Data register (update only when i_en=1):
//    - i_init=1: data <= {q, data[31:W]}.
//    - i_init=0: data <= {{W{data[31]&i_sh_signed}}, data[31:W]}.
//    - After 32/W enabled init cycles, data equals rs1+imm (mod 2^32).
//  lsb register:
//    - W>=2: when i_init & i_en & cnt==0, lsb <= q[1:0].
//    - W=1: when i_init & i_en, lsb[0] <= q at cnt==0 and lsb[1] <= q at cnt==1.
//    - lsb holds through shift cycles and stalls.
//  MDU gating:
//    - When MDU=1 and i_mdu_op=1: o_q = data[B:0] & {W{i_en}}, and o_lsb = 2'b00.
//    - Otherwise o_q = data[B:0] and o_lsb = lsb.
//  Simultaneous events: i_init and i_clr_lsb on digit 0 together is legal; the mask applies to digit 0 only.
//  Latency: outputs reflect register state; each enabled cycle is visible at the next rising edge.
// TESTING
//  1. Add with clr_lsb (W=4): rs1=0x10000003, imm=0x00000FFD, both enables=1, clr_lsb=1, 8 init cycles.
//     Required: o_ext_rs1=0x10000FFF, o_dbus_adr=0x10000FFC, o_lsb=2'b11; o_last high on the 8th cycle.
//  2. Stall (W=4): rs1=0x000000FF, imm=0x00000001; hold i_en=0 for 3 cycles at cnt=1.
//     Required: result 0x00000100 and cnt holds during the stall.
//  3. Shift (W=4): data=0x80000000, i_init=0, i_sh_signed=1, 2 enabled cycles.
//     Required: data=0xFF800000. Repeating with i_sh_signed=0 gives 0x00800000.
//  4. Carry clear at wrap: add 0xFFFFFFFF+1, giving 0.
//     Then a second pass adding 0+0 is required to give 0x00000000 (no leaked carry).
//  5. Reset mid-pass: pull i_rst_n low at cnt=5 between clock edges.
//     Required: o_cnt=0, o_ext_rs1=0, o_lsb=0 before the next edge.
//  6. MDU=1, i_mdu_op=1, i_en=0, data=0xF: required o_q=0, o_lsb=0.
//     Also run the W=1 build on test 1: same result after 32 cycles.

Source files
------------

// File: rtl/serv_bufreg_wide_if.sv
// Signal bundle for serv_bufreg_wide: digit inputs, controls and register views.
// The slave modport is the buffer register; the master modport is the controller side.
interface serv_bufreg_wide_if #(
   parameter int unsigned W = 4
);
   localparam int unsigned CW = ((32 / W) > 2) ? $clog2(32 / W) : 1;

   logic          i_en;
   logic          i_init;
   logic          i_mdu_op;
   logic          i_rs1_en;
   logic          i_imm_en;
   logic          i_clr_lsb;
   logic          i_sh_signed;
   logic [W-1:0]  i_rs1;
   logic [W-1:0]  i_imm;
   logic [W-1:0]  o_q;
   logic [1:0]    o_lsb;
   logic [CW-1:0] o_cnt;
   logic          o_last;
   logic [31:0]   o_dbus_adr;
   logic [31:0]   o_ext_rs1;

   modport master (
      output i_en, i_init, i_mdu_op, i_rs1_en, i_imm_en, i_clr_lsb, i_sh_signed,
      output i_rs1, i_imm,
      input  o_q, o_lsb, o_cnt, o_last, o_dbus_adr, o_ext_rs1
   );

   modport slave (
      input  i_en, i_init, i_mdu_op, i_rs1_en, i_imm_en, i_clr_lsb, i_sh_signed,
      input  i_rs1, i_imm,
      output o_q, o_lsb, o_cnt, o_last, o_dbus_adr, o_ext_rs1
   );
endinterface

// File: rtl/serv_bufreg_wide.sv
// Digit-serial buffer register for the SERV datapath: adds rs1+imm W bits per cycle,
// shifts the sum into a 32-bit register and supplies bus address, low bits and shift operand.
module serv_bufreg_wide #(
   parameter int unsigned W   = 4,
   parameter int unsigned MDU = 0,
   parameter int unsigned B   = W - 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   serv_bufreg_wide_if.slave bus
);
   localparam int unsigned   DIGITS   = 32 / W;
   localparam int unsigned   CW       = (DIGITS > 2) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(DIGITS - 1);
   localparam bit            HAS_MDU  = (MDU != 0);

   generate
      if (!(W == 1 || W == 2 || W == 4 || W == 8)) begin : g_bad_w
         $error("serv_bufreg_wide: W must be 1, 2, 4 or 8");
      end
      if (B != W - 1) begin : g_bad_b
         $error("serv_bufreg_wide: B is derived from W and must not be overridden");
      end
   endgenerate

   logic [CW-1:0] r_cnt;
   logic          r_cr;
   logic [31:0]   r_data;
   logic [1:0]    r_lsb;

   logic          w_first;
   logic          w_last;
   logic [W-1:0]  w_mask;
   logic [W-1:0]  w_rs1;
   logic [W-1:0]  w_imm;
   logic [W:0]    w_sum;
   logic [W-1:0]  w_q;
   logic          w_c;
   logic          w_mdu_gate;

   // Digit adder; JALR clears only bit 0 of the immediate, and only on digit 0.
   always_comb begin
      w_first   = (r_cnt == '0);
      w_last    = (r_cnt == LAST_CNT);
      w_mask    = '0;
      w_mask[0] = w_first & bus.i_clr_lsb;
      w_rs1     = bus.i_rs1 & {W{bus.i_rs1_en}};
      w_imm     = bus.i_imm & {W{bus.i_imm_en}} & ~w_mask;
      w_sum     = {1'b0, w_rs1} + {1'b0, w_imm} + {{W{1'b0}}, r_cr};
      w_q       = w_sum[W-1:0];
      w_c       = w_sum[W];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (bus.i_en) begin
         r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

   // Carry survives stalls but is dropped on the last digit so passes stay independent.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cr <= 1'b0;
      end else if (bus.i_en) begin
         r_cr <= w_last ? 1'b0 : w_c;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_data <= '0;
      end else if (bus.i_en) begin
         if (bus.i_init) begin
            r_data <= {w_q, r_data[31:W]};
         end else begin
            r_data <= {{W{r_data[31] & bus.i_sh_signed}}, r_data[31:W]};
         end
      end
   end

   // With a 1-bit digit the two low sum bits arrive on consecutive cycles.
   generate
      if (W == 1) begin : g_lsb_serial
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_lsb <= '0;
            end else if (bus.i_init && bus.i_en) begin
               if (r_cnt == CW'(0)) begin
                  r_lsb[0] <= w_q[0];
               end
               if (r_cnt == CW'(1)) begin
                  r_lsb[1] <= w_q[0];
               end
            end
         end
      end else begin : g_lsb_parallel
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_lsb <= '0;
            end else if (bus.i_init && bus.i_en && w_first) begin
               r_lsb <= w_q[1:0];
            end
         end
      end
   endgenerate

   always_comb begin
      w_mdu_gate     = HAS_MDU & bus.i_mdu_op;
      bus.o_q        = r_data[B:0] & {W{~w_mdu_gate | bus.i_en}};
      bus.o_lsb      = w_mdu_gate ? 2'b00 : r_lsb;
      bus.o_cnt      = r_cnt;
      bus.o_last     = w_last;
      bus.o_dbus_adr = {r_data[31:2], 2'b00};
      bus.o_ext_rs1  = r_data;
   end
endmodule

// File: tb/tb_serv_bufreg_wide.sv
// Directed bench for serv_bufreg_wide: W=4, W=4 with MDU, and W=1 builds side by side.
module tb_serv_bufreg_wide;
   logic        i_clk = 1'b0;
   logic        i_rst_n;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   serv_bufreg_wide_if #(.W(4)) if4  ();
   serv_bufreg_wide_if #(.W(4)) if4m ();
   serv_bufreg_wide_if #(.W(1)) if1  ();

   serv_bufreg_wide #(.W(4), .MDU(0)) u_dut4  (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(if4.slave));
   serv_bufreg_wide #(.W(4), .MDU(1)) u_dut4m (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(if4m.slave));
   serv_bufreg_wide #(.W(1), .MDU(0)) u_dut1  (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(if1.slave));

   // MDU build mirrors the W=4 stimulus
   assign if4m.i_en        = if4.i_en;
   assign if4m.i_init      = if4.i_init;
   assign if4m.i_mdu_op    = if4.i_mdu_op;
   assign if4m.i_rs1_en    = if4.i_rs1_en;
   assign if4m.i_imm_en    = if4.i_imm_en;
   assign if4m.i_clr_lsb   = if4.i_clr_lsb;
   assign if4m.i_sh_signed = if4.i_sh_signed;
   assign if4m.i_rs1       = if4.i_rs1;
   assign if4m.i_imm       = if4.i_imm;

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic set4(input logic en, input logic init, input logic ops, input logic clr,
                       input logic sh, input logic mdu, input logic [3:0] rs1, input logic [3:0] imm);
      if4.i_en        = en;
      if4.i_init      = init;
      if4.i_rs1_en    = ops;
      if4.i_imm_en    = ops;
      if4.i_clr_lsb   = clr;
      if4.i_sh_signed = sh;
      if4.i_mdu_op    = mdu;
      if4.i_rs1       = rs1;
      if4.i_imm       = imm;
   endtask

   task automatic set1(input logic en, input logic clr, input logic rs1, input logic imm);
      if1.i_en        = en;
      if1.i_init      = en;
      if1.i_rs1_en    = en;
      if1.i_imm_en    = en;
      if1.i_clr_lsb   = clr;
      if1.i_sh_signed = 1'b0;
      if1.i_mdu_op    = 1'b0;
      if1.i_rs1       = rs1;
      if1.i_imm       = imm;
   endtask

   task automatic add4(input logic [31:0] rs1, input logic [31:0] imm, input logic clr,
                       input int stall_at, input int stall_len);
      for (int i = 0; i < 8; i++) begin
         if (i == stall_at) begin
            for (int s = 0; s < stall_len; s++) begin
               @(negedge i_clk);
               check("stall_cnt", 32'(if4.o_cnt), 32'(i));
               set4(1'b0, 1'b1, 1'b1, clr, 1'b0, 1'b0, 4'hA, 4'h5);
            end
         end
         @(negedge i_clk);
         check("pass_cnt", 32'(if4.o_cnt), 32'(i));
         check("pass_last", 32'(if4.o_last), (i == 7) ? 32'd1 : 32'd0);
         set4(1'b1, 1'b1, 1'b1, clr, 1'b0, 1'b0, rs1[4*i +: 4], imm[4*i +: 4]);
      end
      @(negedge i_clk);
      set4(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
   endtask

   task automatic shift4(input int n, input logic sh);
      for (int i = 0; i < n; i++) begin
         @(negedge i_clk);
         set4(1'b1, 1'b0, 1'b0, 1'b0, sh, 1'b0, 4'h0, 4'h0);
      end
      @(negedge i_clk);
      set4(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
   endtask

   task automatic add1(input logic [31:0] rs1, input logic [31:0] imm, input logic clr);
      for (int i = 0; i < 32; i++) begin
         @(negedge i_clk);
         if (i == 31) check("w1_last", 32'(if1.o_last), 32'd1);
         set1(1'b1, clr, rs1[i], imm[i]);
      end
      @(negedge i_clk);
      set1(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      i_rst_n = 1'b0;
      set4(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
      set1(1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      check("rst_q",    32'(if4.o_q),    32'h0);
      check("rst_lsb",  32'(if4.o_lsb),  32'h0);
      check("rst_cnt",  32'(if4.o_cnt),  32'h0);
      check("rst_last", 32'(if4.o_last), 32'h0);
      check("rst_adr",  if4.o_dbus_adr,  32'h0);
      check("rst_ext",  if4.o_ext_rs1,   32'h0);
      check("rst_w1_cnt", 32'(if1.o_cnt), 32'h0);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // add with JALR-style lsb clear: 0x10000003 + 0xFFC
      add4(32'h10000003, 32'h00000FFD, 1'b1, -1, 0);
      check("t1_ext", if4.o_ext_rs1,  32'h10000FFF);
      check("t1_adr", if4.o_dbus_adr, 32'h10000FFC);
      check("t1_lsb", 32'(if4.o_lsb), 32'h3);
      check("t1_q",   32'(if4.o_q),   32'hF);
      check("t1_cnt", 32'(if4.o_cnt), 32'h0);

      // stall three cycles at digit 1 with a pending carry
      add4(32'h000000FF, 32'h00000001, 1'b0, 1, 3);
      check("t2_ext", if4.o_ext_rs1,  32'h00000100);
      check("t2_lsb", 32'(if4.o_lsb), 32'h0);

      add4(32'h80000000, 32'h0, 1'b0, -1, 0);
      shift4(2, 1'b1);
      check("t3_sra2", if4.o_ext_rs1, 32'hFF800000);
      shift4(6, 1'b1);
      check("t3_sra8", if4.o_ext_rs1, 32'hFFFFFFFF);
      check("t3_cnt",  32'(if4.o_cnt), 32'h0);
      check("t3_lsb",  32'(if4.o_lsb), 32'h0);
      add4(32'h80000000, 32'h0, 1'b0, -1, 0);
      shift4(2, 1'b0);
      check("t3_srl2", if4.o_ext_rs1, 32'h00800000);
      shift4(6, 1'b0);
      check("t3_srl8", if4.o_ext_rs1, 32'h00000000);

      add4(32'hFFFFFFFF, 32'h00000001, 1'b0, -1, 0);
      check("t4_wrap", if4.o_ext_rs1, 32'h00000000);
      add4(32'h0, 32'h0, 1'b0, -1, 0);
      check("t4_noleak", if4.o_ext_rs1, 32'h00000000);

      // abort a pass at digit 5 with an asynchronous reset
      for (int i = 0; i < 5; i++) begin
         @(negedge i_clk);
         set4(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'(32'h12345678 >> (4*i)), 4'h1);
      end
      @(negedge i_clk);
      set4(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
      check("t5_pre_cnt", 32'(if4.o_cnt), 32'h5);
      check("t5_pre_lsb", 32'(if4.o_lsb), 32'h1);
      #2 i_rst_n = 1'b0;
      #1;
      check("t5_cnt",  32'(if4.o_cnt),  32'h0);
      check("t5_ext",  if4.o_ext_rs1,   32'h0);
      check("t5_lsb",  32'(if4.o_lsb),  32'h0);
      check("t5_last", 32'(if4.o_last), 32'h0);
      check("t5_adr",  if4.o_dbus_adr,  32'h0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      add4(32'h12345678, 32'h11111111, 1'b0, -1, 0);
      check("t5_after", if4.o_ext_rs1,  32'h23456789);
      check("t5_alsb",  32'(if4.o_lsb), 32'h1);

      add4(32'h0000000F, 32'h0, 1'b0, -1, 0);
      set4(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
      #1;
      check("t6_mdu_q",    32'(if4m.o_q),   32'h0);
      check("t6_mdu_lsb",  32'(if4m.o_lsb), 32'h0);
      check("t6_nomdu_q",  32'(if4.o_q),    32'hF);
      check("t6_nomdu_lsb", 32'(if4.o_lsb), 32'h3);
      set4(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
      #1;
      check("t6_off_q",   32'(if4m.o_q),   32'hF);
      check("t6_off_lsb", 32'(if4m.o_lsb), 32'h3);

      add1(32'h10000003, 32'h00000FFD, 1'b1);
      check("w1_ext", if1.o_ext_rs1,  32'h10000FFF);
      check("w1_adr", if1.o_dbus_adr, 32'h10000FFC);
      check("w1_lsb", 32'(if1.o_lsb), 32'h3);
      check("w1_q",   32'(if1.o_q),   32'h1);
      check("w1_cnt", 32'(if1.o_cnt), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of directed sequence");
      $fatal(1, "simulation time limit reached");
   end
endmodule
